multi_slave_bridge: RTL and testbench

MULTI_SLAVE_BRIDGE -- requirements
Module: multi_slave_bridge

---
 rtl/multi_slave_bridge.sv | 166 ++++++++++++++++
 tb/tb_multi_slave_bridge.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/multi_slave_bridge.sv
// CPU-to-slave bridge: address decode across NSLV slots, per-slot wait states,
// a sticky unmapped-access error register, and per-slot write strobes.
module multi_slave_bridge #(
  parameter int                 NSLV     = 4,
  parameter logic [NSLV*32-1:0] SLV_BASE = {32'h0000_7F20, 32'h0000_7F10, 32'h0000_7F00, 32'h0000_0000},
  parameter logic [NSLV*32-1:0] SLV_MASK = {32'hFFFF_FFFC, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_C000},
  parameter logic [NSLV*4-1:0]  SLV_WAIT = {4'd1, 4'd2, 4'd0, 4'd0}
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic [31:0]          cpu_addr,
  input  logic [31:0]          cpu_wdata,
  input  logic [3:0]           cpu_byteen,
  output logic [31:0]          cpu_rdata,
  output logic                 cpu_stall,
  input  logic                 err_clr,
  output logic [31:0]          slv_addr,
  output logic [31:0]          slv_wdata,
  output logic [NSLV*4-1:0]    slv_byteen,
  input  logic [NSLV*32-1:0]   slv_rdata,
  output logic                 bus_err,
  output logic [31:0]          err_addr
);

  localparam int SW = $clog2(NSLV);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t          state_r;
  logic [3:0]      cnt_r;
  logic [SW-1:0]   sel_r;
  logic            bus_err_r;
  logic [31:0]     err_addr_r;

  logic            hit_s;
  logic [SW-1:0]   hit_idx_s;
  logic [3:0]      hit_wait_s;
  logic            complete_s;
  logic            stall_s;
  logic [SW-1:0]   cmp_idx_s;
  logic [NSLV*4-1:0] byteen_s;
  logic [31:0]     rdata_s;
  logic            unmapped_s;

  assign slv_addr   = cpu_addr;
  assign slv_wdata  = cpu_wdata;
  assign bus_err    = bus_err_r;
  assign err_addr   = err_addr_r;
  assign slv_byteen = byteen_s;
  assign cpu_rdata  = rdata_s;
  assign cpu_stall  = stall_s;

  // Address decode; scanning downward lets the lowest matching slot win.
  always_comb begin
    hit_s     = 1'b0;
    hit_idx_s = {SW{1'b0}};
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((cpu_addr & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32]) begin
        hit_s     = 1'b1;
        hit_idx_s = SW'(i);
      end else begin
        hit_s     = hit_s;
      end
    end
    hit_wait_s = SLV_WAIT[{hit_idx_s, 2'b00} +: 4];
  end

  // Same-cycle access outputs: stall, strobe steering and read-data mux.
  always_comb begin
    complete_s = 1'b0;
    stall_s    = 1'b0;
    cmp_idx_s  = hit_idx_s;
    byteen_s   = {(NSLV*4){1'b0}};
    rdata_s    = 32'h0000_0000;
    unmapped_s = 1'b0;
    if (reset) begin
      complete_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cpu_req && hit_s) begin
            if (hit_wait_s == 4'd0) begin
              complete_s = 1'b1;
            end else begin
              stall_s = 1'b1;
            end
          end else begin
            unmapped_s = cpu_req;
          end
        end
        ST_WAIT: begin
          cmp_idx_s = sel_r;
          if (!cpu_req) begin
            complete_s = 1'b0;
          end else if (cnt_r == 4'd0) begin
            complete_s = 1'b1;
          end else begin
            stall_s = 1'b1;
          end
        end
        default: begin
          complete_s = 1'b0;
        end
      endcase
    end
    if (complete_s) begin
      byteen_s[{cmp_idx_s, 2'b00} +: 4] = cpu_byteen;
      rdata_s = slv_rdata[{cmp_idx_s, 5'd0} +: 32];
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  // Access FSM: wait-state counting, slot latch, abort on dropped request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      sel_r   <= {SW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cpu_req && hit_s && (hit_wait_s != 4'd0)) begin
            state_r <= ST_WAIT;
            cnt_r   <= hit_wait_s - 4'd1;
            sel_r   <= hit_idx_s;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (!cpu_req || (cnt_r == 4'd0)) begin
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= 4'd0;
        end
      endcase
    end
  end

  // Sticky error capture; a new unmapped access beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_err_r  <= 1'b0;
      err_addr_r <= 32'h0000_0000;
    end else if (unmapped_s) begin
      bus_err_r <= 1'b1;
      if (!bus_err_r || err_clr) begin
        err_addr_r <= cpu_addr;
      end else begin
        err_addr_r <= err_addr_r;
      end
    end else if (err_clr) begin
      bus_err_r <= 1'b0;
    end else begin
      bus_err_r <= bus_err_r;
    end
  end

endmodule

// File: tb/tb_multi_slave_bridge.sv
// Scoreboard bench for multi_slave_bridge: directed accesses push expected
// completions; a negedge monitor pops and compares each completed access.
module tb_multi_slave_bridge;

  localparam int NSLV = 4;

  logic              clk;
  logic              reset;
  logic              cpu_req;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [3:0]        cpu_byteen;
  logic [31:0]       cpu_rdata;
  logic              cpu_stall;
  logic              err_clr;
  logic [31:0]       slv_addr;
  logic [31:0]       slv_wdata;
  logic [NSLV*4-1:0] slv_byteen;
  logic [NSLV*32-1:0] slv_rdata;
  logic              bus_err;
  logic [31:0]       err_addr;

  typedef struct {
    logic [31:0] rdata;
    logic [15:0] be;
    int          stalls;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   stall_cnt = 0;

  multi_slave_bridge dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_byteen (cpu_byteen),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .err_clr    (err_clr),
    .slv_addr   (slv_addr),
    .slv_wdata  (slv_wdata),
    .slv_byteen (slv_byteen),
    .slv_rdata  (slv_rdata),
    .bus_err    (bus_err),
    .err_addr   (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: strobes must stay quiet while stalled; each completion is scored.
  always @(negedge clk) begin
    if (reset || !cpu_req) begin
      stall_cnt = 0;
    end else if (cpu_stall) begin
      chk("stall_byteen", {16'h0, slv_byteen}, 32'h0);
      stall_cnt++;
    end else begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_completion: addr %h with empty scoreboard", cpu_addr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rdata", cpu_rdata, e.rdata);
        chk("byteen", {16'h0, slv_byteen}, {16'h0, e.be});
        chk("latency_stalls", stall_cnt, e.stalls);
        chk("slv_addr", slv_addr, cpu_addr);
      end
      stall_cnt = 0;
    end
  end

  task automatic access(input logic [31:0] a, input logic [31:0] w, input logic [3:0] be,
                        input logic [31:0] er, input int es, input logic [15:0] eb);
    int n;
    exp_t e;
    e.rdata = er; e.be = eb; e.stalls = es;
    exp_q.push_back(e);
    cpu_req = 1'b1; cpu_addr = a; cpu_wdata = w; cpu_byteen = be;
    n = 0;
    forever begin
      @(negedge clk);
      if (!cpu_stall) break;
      n++;
      if (n > 20) begin
        n_vec++;
        n_fail++;
        $display("FAIL access_timeout: addr %h still stalled after %0d cycles, expected %0d", a, n, es);
        break;
      end
    end
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_byteen = 4'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    slv_rdata  = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};
    reset      = 1'b1;
    err_clr    = 1'b0;
    cpu_req    = 1'b1;
    cpu_addr   = 32'h0000_1000;
    cpu_wdata  = 32'h1234_5678;
    cpu_byteen = 4'hF;
    // outputs held quiet while reset is asserted, even with a live request
    @(negedge clk);
    chk("reset_stall", {31'h0, cpu_stall}, 32'h0);
    chk("reset_byteen", {16'h0, slv_byteen}, 32'h0);
    chk("reset_rdata", cpu_rdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0; cpu_req = 1'b0; cpu_byteen = 4'h0;
    chk("reset_bus_err", {31'h0, bus_err}, 32'h0);
    chk("reset_err_addr", err_addr, 32'h0);

    // zero-wait read, then back-to-back wait-state accesses
    access(32'h0000_1000, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, 16'h0000);
    access(32'h0000_7F14, 32'hA5A5_A5A5, 4'hF, 32'h2222_2222, 2, 16'h0F00);
    access(32'h0000_7F20, 32'h0, 4'h0, 32'h3333_3333, 1, 16'h0000);
    access(32'h0000_7F23, 32'h5555_0000, 4'h5, 32'h3333_3333, 1, 16'h5000);
    access(32'h0000_7F04, 32'hCAFE_0000, 4'h3, 32'h1111_1111, 0, 16'h0030);
    access(32'h0000_3FFC, 32'h0, 4'h8, 32'hDEAD_BEEF, 0, 16'h0008);

    // unmapped accesses: first address sticks, no strobe, no stall
    access(32'h0000_9000, 32'h0, 4'h0, 32'h0, 0, 16'h0000);
    access(32'h0000_A000, 32'hFFFF_FFFF, 4'hF, 32'h0, 0, 16'h0000);
    chk("err_set", {31'h0, bus_err}, 32'h1);
    chk("err_first_addr", err_addr, 32'h0000_9000);
    err_clr = 1'b1;
    access(32'h0000_B000, 32'h0, 4'h0, 32'h0, 0, 16'h0000);
    err_clr = 1'b0;
    chk("err_set_beats_clr", {31'h0, bus_err}, 32'h1);
    chk("err_addr_new", err_addr, 32'h0000_B000);

    // reset in the second stall cycle of a wait-2 write
    cpu_req = 1'b1; cpu_addr = 32'h0000_7F14; cpu_wdata = 32'h0BAD_0BAD; cpu_byteen = 4'hF;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("midwait_reset_byteen", {16'h0, slv_byteen}, 32'h0);
    chk("midwait_reset_stall", {31'h0, cpu_stall}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0; cpu_req = 1'b0; cpu_byteen = 4'h0;
    chk("midwait_reset_bus_err", {31'h0, bus_err}, 32'h0);
    access(32'h0000_0000, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, 16'h0000);

    // error capture after clear, then err_clr alone
    access(32'h0000_C000, 32'h0, 4'h0, 32'h0, 0, 16'h0000);
    access(32'h0000_D000, 32'h0, 4'h0, 32'h0, 0, 16'h0000);
    chk("err_addr_first_after_reset", err_addr, 32'h0000_C000);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("err_cleared", {31'h0, bus_err}, 32'h0);

    // request dropped in first wait cycle aborts without a strobe
    cpu_req = 1'b1; cpu_addr = 32'h0000_7F14; cpu_wdata = 32'h0BAD_F00D; cpu_byteen = 4'hF;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(negedge clk);
    chk("abort_stall", {31'h0, cpu_stall}, 32'h0);
    chk("abort_byteen", {16'h0, slv_byteen}, 32'h0);
    @(posedge clk); #1;
    access(32'h0000_0004, 32'h7777_7777, 4'hF, 32'hDEAD_BEEF, 0, 16'h000F);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
